storage_arbiter: RTL and testbench
==================================

Name: storage_arbiter

Overview:
- Shares the single `storage_controller` memory port (`memory_access`/`out_valid` interface) between NUM_REQ requesters, e.g. 0 = instruction fetch, 1 = scalar LSU, 2 = vector LSU.
- Selects one requester, sequences one transaction to completion, returns read data, then re-arbitrates.
- Sits between the core/vector memory units and `storage_controller`; gates new grants while the SoC is in programming mode.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, WAIT cycles allowed before a read is aborted; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- prog_mode  in  1  mirrors `set_programming_mode`; blocks new grants
- req_valid  in  NUM_REQ  per-requester request; held with its fields stable until its req_done or req_err
- req_we  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*32  byte address, requester i at [32i+31:32i]
- req_wdata  in  NUM_REQ*32  write data
- req_be  in  NUM_REQ*4  byte enables
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  out  NUM_REQ  one-cycle timeout pulse to the granted requester
- rsp_rdata  out  32  read data, valid with req_done
- busy  out  1  high in any state other than IDLE
- memory_access  out  1  to storage_controller
- memory_is_writing  out  1  to storage_controller
- addr  out  32  to storage_controller
- d_in  out  32  to storage_controller
- mem_be  out  4  to storage_controller
- d_out  in  32  from storage_controller
- out_valid  in  1  from storage_controller

Behaviour:
- Reset (async, any state):
  - all outputs 0; state IDLE; grant index 0; timeout counter 0; rsp_rdata 0.
  - An in-flight transaction is dropped with no done/err pulse.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - If prog_mode=0 and any req_valid is set, pick a winner, register its index and latch its we/addr/wdata/be into holding registers, then go to ISSUE.
  - Otherwise stay in IDLE.
  - Storage port outputs are all 0.
- Arbitration (default): fixed priority, lowest index wins.
- ISSUE (1 cycle):
  - memory_access=1; addr/d_in/mem_be/memory_is_writing driven from the holding registers.
  - Write: next state RELEASE. The write is accepted in this single cycle.
  - Read: next state WAIT.
- WAIT:
  - memory_access=1, other outputs held.
  - out_valid=1: capture d_out into rsp_rdata, go to RELEASE with done.
  - Otherwise increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1, go to RELEASE with err and set rsp_rdata=0.
  - out_valid seen in ISSUE is ignored.
- RELEASE (1 cycle):
  - memory_access=0 and all port outputs 0. This guarantees at least one idle cycle between transactions.
  - req_done[g] or req_err[g] pulses in this cycle only; rsp_rdata is valid and held until the next completion.
  - Counter cleared; next state IDLE.
- Latency:
  - Write: request seen in IDLE to req_done = 2 cycles.
  - Read: 2 cycles + the number of WAIT cycles until out_valid.
  - Minimum back-to-back period = 3 cycles (write), since IDLE is always re-entered.
- prog_mode:
  - Checked only in IDLE; an in-flight transaction always completes.
  - Requesters stay pending, unserviced, until prog_mode=0.
- Requester violations:
  - A requester dropping req_valid mid-transaction does not abort it; the latched fields are used.
  - req_valid of non-granted requesters is ignored.
- Simultaneous events:
  - out_valid on the cycle the timeout would fire: out_valid wins (done, not err).

Optional Feature:
- Macro STORAGE_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-grant pointer (reset 0) is updated on every RELEASE.
  - Search starts at pointer+1 modulo NUM_REQ, so a continuously requesting requester waits at most NUM_REQ-1 transactions.
- Undefined: fixed priority as above, with no pointer logic.

Test Plan:
- Single write: req 1 write addr=0x0000_0040, wdata=0xDEAD_BEEF, be=0xF.
  - addr/d_in/mem_be/memory_is_writing=1 appear for exactly 1 cycle with memory_access=1.
  - req_done[1] follows 2 cycles after the request.
- Read: req 0 read addr=0x0000_0040; bench returns d_out=0xDEAD_BEEF with out_valid after 5 cycles.
  - memory_access held high through WAIT.
  - req_done[0] pulses with rsp_rdata=0xDEAD_BEEF, followed by memory_access=0 for ≥1 cycle.
- Contention: req 0, 1 and 2 all assert reads together.
  - Fixed priority: service order 0,1,2.
  - With STORAGE_ARB_RR_EN, after a prior grant to 1: order 2,0,1.
  - No overlap of memory_access between grants.
- Timeout: TIMEOUT_CYCLES=8, read with out_valid never asserted.
  - req_err pulses after 8 WAIT cycles with rsp_rdata=0; no req_done.
  - A following write from another requester is serviced normally.
- prog_mode: prog_mode asserted during an in-flight read.
  - The read completes; a pending req 2 is not granted until 1 cycle after prog_mode deasserts.
- Reset mid-read: rst asserted in WAIT.
  - All outputs 0 immediately (async); no done/err pulse; state IDLE after release.

Source files
------------

// File: rtl/storage_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single storage_controller port, one transaction at a time.
// Optional macro STORAGE_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module storage_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]  req_be,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic [31:0]           rsp_rdata,
    output logic                  busy,
    output logic                  memory_access,
    output logic                  memory_is_writing,
    output logic [31:0]           addr,
    output logic [31:0]           d_in,
    output logic [3:0]            mem_be,
    input  logic [31:0]           d_out,
    input  logic                  out_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [31:0]        rsp_q, rsp_d;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               port_active;

`ifdef STORAGE_ARB_RR_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               found;
    int unsigned        cand;

    // Search begins one past the last granted requester so everyone gets a turn.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        cand    = 0;
        any_req = |req_valid;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner  = '0;
        any_req = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rsp_d   = rsp_q;
`ifdef STORAGE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!prog_mode && any_req) begin
                    grant_d = winner;
                    we_d    = req_we[winner];
                    addr_d  = req_addr[int'(winner)*32 +: 32];
                    wdata_d = req_wdata[int'(winner)*32 +: 32];
                    be_d    = req_be[int'(winner)*4 +: 4];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = we_q ? ST_RELEASE : ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the timeout cycle still counts as success.
                if (out_valid) begin
                    rsp_d   = d_out;
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
`ifdef STORAGE_ARB_RR_EN
                ptr_d   = grant_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
`ifdef STORAGE_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
`ifdef STORAGE_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Port outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        port_active       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        busy              = (state_q != ST_IDLE);
        memory_access     = port_active;
        memory_is_writing = port_active & we_q;
        addr              = port_active ? addr_q : '0;
        d_in              = port_active ? wdata_q : '0;
        mem_be            = port_active ? be_q : '0;
        rsp_rdata         = rsp_q;
        req_done          = '0;
        req_err           = '0;
        if (state_q == ST_RELEASE) begin
            if (err_q) begin
                req_err[grant_q] = 1'b1;
            end else begin
                req_done[grant_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench for storage_arbiter: directed and randomized transactions against a
// transaction-level model of arbitration order, latency and memory contents.
module tb_storage_arbiter;

    localparam int NR  = 3;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prog_mode = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*32-1:0]  req_addr = '0;
    logic [NR*32-1:0]  req_wdata = '0;
    logic [NR*4-1:0]   req_be = '0;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [31:0]       rsp_rdata;
    logic              busy;
    logic              memory_access;
    logic              memory_is_writing;
    logic [31:0]       addr;
    logic [31:0]       d_in;
    logic [3:0]        mem_be;
    logic [31:0]       d_out = '0;
    logic              out_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    int rsp_lat = 1;
    int hi_cnt = 0;
    int ptr_m = 0;

    logic [31:0] port_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    storage_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .prog_mode(prog_mode),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .req_done(req_done),
        .req_err(req_err),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .memory_access(memory_access),
        .memory_is_writing(memory_is_writing),
        .addr(addr),
        .d_in(d_in),
        .mem_be(mem_be),
        .d_out(d_out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] portRead(logic [31:0] a);
        return port_mem.exists(a) ? port_mem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] refRead(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initVal(a);
    endfunction

    // Expected winner among pending requesters under the arbitration policy being built.
    function automatic int pickWinner(logic [NR-1:0] v);
        int w = -1;
`ifdef STORAGE_ARB_RR_EN
        for (int k = 1; k <= NR; k++) if (w < 0 && v[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
`else
        for (int k = 0; k < NR; k++) if (w < 0 && v[k]) w = k;
`endif
        return w;
    endfunction

    // Memory responder: stores writes seen on the port, answers reads in WAIT cycle rsp_lat.
    always @(negedge clk) begin
        if (memory_access) hi_cnt = hi_cnt + 1;
        else hi_cnt = 0;
        out_valid = 1'b0;
        d_out = $urandom;
        if (memory_access && memory_is_writing && hi_cnt == 1) begin
            port_mem[addr] = merge(portRead(addr), d_in, mem_be);
        end else if (memory_access && !memory_is_writing && rsp_lat != 0 && hi_cnt == rsp_lat + 1) begin
            out_valid = 1'b1;
            d_out = portRead(addr);
        end
    end

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(int i, logic v, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_be[4*i +: 4]      = be;
    endtask

    // One transaction from an IDLE negedge through RELEASE and back into IDLE.
    task automatic doTxn(int i, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be, int lat);
        int expK;
        int k;
        int gaps;
        bit got;
        logic [31:0] expR;
        expK = we ? 2 : ((lat == 0) ? 2 + TMO : 2 + lat);
        expR = (lat == 0) ? 32'h0 : refRead(a);
        if (we) ref_mem[a] = merge(refRead(a), wd, be);
        rsp_lat = we ? 1 : lat;
        applyStimulus(i, 1'b1, we, a, wd, be);
        k = 0;
        gaps = 0;
        got = 1'b0;
        while (!got && k < expK + 16) begin
            @(negedge clk);
            k++;
            if (req_done != 0 || req_err != 0) begin
                got = 1'b1;
            end else begin
                if (!memory_access) gaps++;
                if (k == 1) begin
                    checkOutput("issue_we", 32'(memory_is_writing), 32'(we));
                    checkOutput("issue_addr", addr, a);
                    checkOutput("issue_be", 32'(mem_be), 32'(be));
                    if (we) checkOutput("issue_wdata", d_in, wd);
                end
            end
        end
        checkOutput("latency", k, expK);
        checkOutput("access_gaps", gaps, 0);
        checkOutput("done_vec", 32'(req_done), (we || lat != 0) ? (1 << i) : 0);
        checkOutput("err_vec", 32'(req_err), (!we && lat == 0) ? (1 << i) : 0);
        if (!we) checkOutput("rdata", rsp_rdata, expR);
        checkOutput("release_idle", 32'(memory_access), 0);
        req_valid[i] = 1'b0;
        ptr_m = i;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_done", 32'(req_done), 0);
    endtask

    // All requesters read at once; completions must follow the policy order with idle gaps.
    task automatic doContention(int lat);
        logic [31:0] a [NR];
        logic [NR-1:0] pend;
        int w;
        int k;
        bit got;
        rsp_lat = lat;
        for (int i = 0; i < NR; i++) begin
            a[i] = 32'($urandom_range(0, 15)) << 2;
            applyStimulus(i, 1'b1, 1'b0, a[i], 32'h0, 4'hF);
        end
        pend = '1;
        repeat (NR) begin
            w = pickWinner(pend);
            k = 0;
            got = 1'b0;
            while (!got && k < 40) begin
                @(negedge clk);
                k++;
                got = (req_done != 0 || req_err != 0);
            end
            checkOutput("cont_latency", k, 2 + lat);
            checkOutput("cont_done", 32'(req_done), 1 << w);
            checkOutput("cont_rdata", rsp_rdata, refRead(a[w]));
            req_valid[w] = 1'b0;
            pend[w] = 1'b0;
            ptr_m = w;
            @(negedge clk);
            checkOutput("cont_gap", 32'(memory_access), 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ri;
        int rlat;
        logic rwe;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [3:0] rbe;
        int k;
        bit got;
        logic [31:0] expR;

        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_access", 32'(memory_access), 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_done", 32'(req_done), 0);
        checkOutput("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single write then read back");
        doTxn(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0);
        doTxn(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 5);

        $display("[TB] randomized single transactions");
        for (int n = 0; n < 24; n++) begin
            ri    = $urandom_range(0, NR - 1);
            rwe   = 1'($urandom_range(0, 1));
            raddr = 32'($urandom_range(0, 7)) << 2;
            rdata = $urandom;
            rbe   = 4'($urandom_range(0, 15));
            rlat  = $urandom_range(1, 4);
            doTxn(ri, rwe, raddr, rdata, rbe, rlat);
        end

        $display("[TB] contention");
        doContention($urandom_range(1, 3));
        doTxn(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2);
        doContention($urandom_range(1, 3));

        $display("[TB] timeout then write from another requester");
        doTxn(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 0);
        doTxn(2, 1'b1, 32'h0000_0084, 32'hCAFE_F00D, 4'hF, 0);
        doTxn(1, 1'b0, 32'h0000_0084, 32'h0, 4'hF, 1);

        $display("[TB] programming mode during a read");
        rsp_lat = 4;
        expR = refRead(32'h0000_0040);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        @(negedge clk);
        k = 1;
        prog_mode = 1'b1;
        applyStimulus(2, 1'b1, 1'b1, 32'h0000_0050, 32'h1234_5678, 4'hF);
        ref_mem[32'h0000_0050] = 32'h1234_5678;
        got = 1'b0;
        while (!got && k < 30) begin
            @(negedge clk);
            k++;
            got = (req_done != 0 || req_err != 0);
        end
        checkOutput("prog_latency", k, 6);
        checkOutput("prog_done", 32'(req_done), 32'h2);
        checkOutput("prog_rdata", rsp_rdata, expR);
        req_valid[1] = 1'b0;
        ptr_m = 1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("prog_hold", 32'(busy), 0);
        end
        prog_mode = 1'b0;
        @(negedge clk);
        checkOutput("prog_issue", 32'(memory_access), 1);
        checkOutput("prog_addr", addr, 32'h0000_0050);
        @(negedge clk);
        checkOutput("prog_grant", 32'(req_done), 32'h4);
        req_valid[2] = 1'b0;
        ptr_m = 2;
        @(negedge clk);
        doTxn(0, 1'b0, 32'h0000_0050, 32'h0, 4'hF, 3);

        $display("[TB] reset during WAIT");
        rsp_lat = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_access", 32'(memory_access), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_access", 32'(memory_access), 0);
        checkOutput("async_busy", 32'(busy), 0);
        checkOutput("async_addr", addr, 0);
        checkOutput("async_rdata", rsp_rdata, 0);
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_pulse", 32'(req_done | req_err), 0);
        end
        rst = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 0);
        doTxn(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
